and8_qual: RTL and testbench
============================

AND8_QUAL -- requirements
Module: and8_qual

Interface
REQ-001 Parameter HOLD, default 3, number of CE-qualified hold-off cycles after a match ends; legal range 0..15.
REQ-002 CK  input  1  clock; all state updates on rising edge.
REQ-003 CD  input  1  reset; synchronous and active-high, sampled on the rising edge of CK.
REQ-004 CE  input  1  clock enable; state advances only on edges where CE=1.
REQ-005 A0..A7  input  1 each  term inputs, one bit per port, to be AND-qualified.
REQ-006 TH  input  4  run-length threshold; TH=0 SHALL be treated as 1.
REQ-007 Z0  output  1  qualified match level, registered.
REQ-008 ZP  output  1  one-cycle pulse on match entry, registered.
REQ-009 CNT  output  4  current consecutive-high run count, registered, saturating.

Function
REQ-010 Input stage SHALL register A0..A7 on each CE=1 edge; internal term m = AND of the eight registered bits.
REQ-011 The FSM SHALL have four states: IDLE, RUN, MATCH, HOLDOFF. The FSM evaluates m, as registered at the previous edge.
REQ-012 CNT update:
- m=1: CNT+1, saturating at 15.
- m=0: CNT cleared to 0.
- In HOLDOFF: CNT held at 0.
REQ-013 Effective threshold: eff = (TH==0) ? 1 : TH. TH is compared live every cycle and is not latched.
REQ-014 IDLE transitions:
- m=1 and next CNT >= eff: go to MATCH.
- m=1 and next CNT < eff: go to RUN.
- Otherwise: stay in IDLE.
REQ-015 RUN transitions:
- m=0: go to IDLE.
- next CNT >= eff: go to MATCH.
- Otherwise: stay in RUN.
REQ-016 MATCH: stays in MATCH while m=1. On m=0 it goes to HOLDOFF with the hold counter loaded to HOLD. If HOLD=0 it goes directly to IDLE.
REQ-017 HOLDOFF: the hold counter decrements on each CE=1 edge and m is ignored. When the counter reaches 0 it goes to IDLE. No MATCH entry is possible until the FSM is back in IDLE.
REQ-018 Z0 SHALL be 1 exactly while the FSM is in MATCH.
REQ-019 ZP SHALL be 1 for exactly one CK cycle, after the edge that enters MATCH. It is 0 after every other edge, including CE=0 edges.
REQ-020 Latency:
- A0..A7 all high from before edge k gives m=1 after edge k.
- Z0 and ZP rise after edge k+eff, with CE=1 throughout.
REQ-021 CE=0: inputs, FSM, CNT, hold counter and Z0 SHALL hold their values; ZP SHALL be forced to 0.
REQ-022 Saturation: CNT stays at 15 under continuous m=1. With TH=15, MATCH is still reached at CNT=15.
REQ-023 TH lowered mid-RUN below the current CNT: MATCH SHALL be entered on the next CE=1 edge with m=1.
REQ-024 A single low cycle on any A input during RUN SHALL return the FSM to IDLE and clear CNT.

Reset
REQ-025 CD=1 on an edge SHALL, regardless of CE, set:
- input register = 0
- FSM = IDLE
- CNT = 0
- hold counter = 0
- Z0 = 0
- ZP = 0
REQ-026 CD SHALL take priority over CE and all FSM transitions, including reset asserted in MATCH or HOLDOFF. The first edge with CD=0 resumes normal operation from IDLE.

Verification
REQ-027 Case 1: TH=3, CE=1, A=all-1 from edge 1 → CNT=1,2,3 after edges 2,3,4; Z0=1 and ZP=1 after edge 4; ZP=0 after edge 5.
REQ-028 Case 2: TH=4, A=all-1 for 3 cycles, then A3=0 for 1 cycle, then all-1 → CNT resets to 0; Z0 first rises 4 cycles after re-high; no ZP before that.
REQ-029 Case 3: HOLD=3, in MATCH, drop A0 for 1 cycle then restore → Z0=0 for HOLDOFF (3 edges) plus re-qualification; ZP fires again only after a new full TH run.
REQ-030 Case 4: TH=0 → behaves as TH=1: Z0 rises 2 edges after A goes all-1. Also TH=15 with 20 high cycles → CNT saturates at 15 and Z0=1.
REQ-031 Case 5: CE=0 for 5 cycles mid-RUN with CNT=2 → CNT stays 2 and ZP stays 0. With CE=1 again, counting resumes at 3.
REQ-032 Case 6: CD=1 asserted while in MATCH with CE=0 → after the edge all outputs are 0 and the FSM is IDLE. Releasing CD with A all-1 and TH=2 → Z0 rises 3 edges later.

Source files
------------

// File: rtl/and8_qual.sv
// Eight-input AND qualifier: registered terms feed a run-length FSM that asserts
// a match level after TH consecutive high cycles, then enforces a hold-off window.
module and8_qual #(
    parameter int unsigned HOLD = 3
) (
    input  logic       CK,
    input  logic       CD,
    input  logic       CE,
    input  logic       A0,
    input  logic       A1,
    input  logic       A2,
    input  logic       A3,
    input  logic       A4,
    input  logic       A5,
    input  logic       A6,
    input  logic       A7,
    input  logic [3:0] TH,
    output logic       Z0,
    output logic       ZP,
    output logic [3:0] CNT
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_MATCH   = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam logic [3:0] HOLD_L = 4'(HOLD);

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] hold_q, hold_d;
    logic       z0_q, z0_d;
    logic       zp_q, zp_d;

    logic       m_s;
    logic [3:0] eff_s;
    logic [3:0] cnt_inc_s;

    // Next-state, counter and output computation; everything holds when CE is low.
    always_comb begin
        a_d       = a_q;
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        z0_d      = z0_q;
        zp_d      = 1'b0;
        m_s       = &a_q;
        eff_s     = (TH == 4'd0) ? 4'd1 : TH;
        cnt_inc_s = (cnt_q == 4'd15) ? 4'd15 : (cnt_q + 4'd1);

        if (CE) begin
            a_d = {A7, A6, A5, A4, A3, A2, A1, A0};
            if (m_s) begin
                cnt_d = cnt_inc_s;
            end else begin
                cnt_d = 4'd0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (m_s && (cnt_inc_s >= eff_s)) begin
                        state_d = ST_MATCH;
                    end else if (m_s) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (!m_s) begin
                        state_d = ST_IDLE;
                    end else if (cnt_inc_s >= eff_s) begin
                        state_d = ST_MATCH;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MATCH: begin
                    if (m_s) begin
                        state_d = ST_MATCH;
                    end else if (HOLD_L == 4'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                        hold_d  = HOLD_L;
                    end
                end
                ST_HOLDOFF: begin
                    // m is ignored here; the run count restarts only once back in IDLE
                    cnt_d = 4'd0;
                    if (hold_q <= 4'd1) begin
                        state_d = ST_IDLE;
                        hold_d  = 4'd0;
                    end else begin
                        state_d = ST_HOLDOFF;
                        hold_d  = hold_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    hold_d  = 4'd0;
                end
            endcase

            z0_d = (state_d == ST_MATCH);
            zp_d = (state_d == ST_MATCH) && (state_q != ST_MATCH);
        end else begin
            zp_d = 1'b0;
        end
    end

    // State registers with synchronous reset taking priority over CE.
    always_ff @(posedge CK) begin
        if (CD) begin
            a_q     <= 8'd0;
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            hold_q  <= 4'd0;
            z0_q    <= 1'b0;
            zp_q    <= 1'b0;
        end else begin
            a_q     <= a_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            z0_q    <= z0_d;
            zp_q    <= zp_d;
        end
    end

    assign Z0  = z0_q;
    assign ZP  = zp_q;
    assign CNT = cnt_q;

endmodule

// File: tb/tb_and8_qual.sv
// Directed self-checking bench for and8_qual; each task checks {Z0,ZP,CNT}
// after every rising edge against hand-computed tables.
module tb_and8_qual;

    logic       CK = 1'b0;
    logic       CD = 1'b0;
    logic       CE = 1'b0;
    logic       A0, A1, A2, A3, A4, A5, A6, A7;
    logic [3:0] TH = 4'd3;
    logic       Z0;
    logic       ZP;
    logic [3:0] CNT;

    int checks = 0;
    int errors = 0;

    and8_qual #(.HOLD(3)) dut (
        .CK(CK), .CD(CD), .CE(CE),
        .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7),
        .TH(TH), .Z0(Z0), .ZP(ZP), .CNT(CNT)
    );

    always #5 CK = ~CK;

    task automatic set_a(input logic [7:0] v);
        {A7, A6, A5, A4, A3, A2, A1, A0} = v;
    endtask

    // One rising edge, then return at the falling edge for sampling/driving.
    task automatic step();
        @(posedge CK);
        @(negedge CK);
    endtask

    task automatic do_reset();
        CD = 1'b1;
        CE = 1'b1;
        set_a(8'h00);
        step();
        CD = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        set_a(8'hFF);
        TH = 4'd3;
        CE = 1'b1;
        CD = 1'b1;
        step();
        step();
        obs = {Z0, ZP, CNT};
        checks++;
        if (obs !== 6'b00_0000) begin
            errors++;
            $display("FAIL reset: got z0,zp,cnt=%b expected %b", obs, 6'b00_0000);
        end
        CD = 1'b0;
    endtask

    task automatic test_case1();
        int ez0 [5] = '{0, 0, 0, 1, 1};
        int ezp [5] = '{0, 0, 0, 1, 0};
        int ecn [5] = '{0, 1, 2, 3, 4};
        logic [5:0] obs, exp_v;
        do_reset();
        TH = 4'd3;
        set_a(8'hFF);
        for (int i = 0; i < 5; i++) begin
            step();
            obs   = {Z0, ZP, CNT};
            exp_v = {1'(ez0[i]), 1'(ezp[i]), 4'(ecn[i])};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL case1 edge %0d: got z0,zp,cnt=%b expected %b", i + 1, obs, exp_v);
            end
        end
    endtask

    // Run broken by one low on A3, then a full re-qualification; ends in MATCH.
    task automatic test_run_break();
        int ez0 [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        int ezp [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
        int ecn [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 4};
        logic [5:0] obs, exp_v;
        do_reset();
        TH = 4'd4;
        for (int i = 0; i < 9; i++) begin
            set_a((i == 3) ? 8'hF7 : 8'hFF);
            step();
            obs   = {Z0, ZP, CNT};
            exp_v = {1'(ez0[i]), 1'(ezp[i]), 4'(ecn[i])};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL run_break edge %0d: got z0,zp,cnt=%b expected %b", i + 1, obs, exp_v);
            end
        end
    endtask

    // Continues from MATCH at TH=4: A0 low for one cycle, 3-edge hold-off, new run.
    task automatic test_holdoff();
        int ez0 [10] = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
        int ezp [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        int ecn [10] = '{5, 0, 0, 0, 0, 1, 2, 3, 4, 5};
        logic [5:0] obs, exp_v;
        for (int i = 0; i < 10; i++) begin
            set_a((i == 0) ? 8'hFE : 8'hFF);
            step();
            obs   = {Z0, ZP, CNT};
            exp_v = {1'(ez0[i]), 1'(ezp[i]), 4'(ecn[i])};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL holdoff edge %0d: got z0,zp,cnt=%b expected %b", i + 1, obs, exp_v);
            end
        end
    endtask

    task automatic test_th_edges();
        int ez0 [3] = '{0, 1, 1};
        int ezp [3] = '{0, 1, 0};
        int ecn [3] = '{0, 1, 2};
        logic [5:0] obs, exp_v;
        do_reset();
        TH = 4'd0;
        set_a(8'hFF);
        for (int i = 0; i < 3; i++) begin
            step();
            obs   = {Z0, ZP, CNT};
            exp_v = {1'(ez0[i]), 1'(ezp[i]), 4'(ecn[i])};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL th0 edge %0d: got z0,zp,cnt=%b expected %b", i + 1, obs, exp_v);
            end
        end
        do_reset();
        TH = 4'd15;
        set_a(8'hFF);
        for (int k = 1; k <= 20; k++) begin
            step();
            obs   = {Z0, ZP, CNT};
            exp_v = {1'(k >= 16), 1'(k == 16), 4'((k - 1 > 15) ? 15 : k - 1)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL th15 edge %0d: got z0,zp,cnt=%b expected %b", k, obs, exp_v);
            end
        end
    endtask

    task automatic test_th_lower();
        logic [5:0] obs;
        do_reset();
        TH = 4'd8;
        set_a(8'hFF);
        for (int i = 0; i < 5; i++) step();
        obs = {Z0, ZP, CNT};
        checks++;
        if (obs !== 6'b00_0100) begin
            errors++;
            $display("FAIL th_lower pre: got z0,zp,cnt=%b expected %b", obs, 6'b00_0100);
        end
        TH = 4'd2;
        step();
        obs = {Z0, ZP, CNT};
        checks++;
        if (obs !== 6'b11_0101) begin
            errors++;
            $display("FAIL th_lower post: got z0,zp,cnt=%b expected %b", obs, 6'b11_0101);
        end
    endtask

    // CE low mid-run freezes everything (A glitches ignored), then counting resumes.
    task automatic test_ce_hold();
        logic [5:0] obs, exp_v;
        do_reset();
        TH = 4'd5;
        set_a(8'hFF);
        for (int i = 0; i < 3; i++) step();
        CE = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_a((i % 2 == 0) ? 8'h00 : 8'h5A);
            step();
            obs = {Z0, ZP, CNT};
            checks++;
            if (obs !== 6'b00_0010) begin
                errors++;
                $display("FAIL ce_hold cycle %0d: got z0,zp,cnt=%b expected %b", i + 1, obs, 6'b00_0010);
            end
        end
        set_a(8'hFF);
        CE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            obs   = {Z0, ZP, CNT};
            exp_v = {1'(i == 2), 1'(i == 2), 4'(3 + i)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL ce_resume edge %0d: got z0,zp,cnt=%b expected %b", i + 1, obs, exp_v);
            end
        end
        CE = 1'b0;
        step();
        obs = {Z0, ZP, CNT};
        checks++;
        if (obs !== 6'b10_0101) begin
            errors++;
            $display("FAIL ce_zp_kill: got z0,zp,cnt=%b expected %b", obs, 6'b10_0101);
        end
    endtask

    // Reset with CE=0 while in MATCH, then requalify at TH=2.
    task automatic test_reset_in_match();
        logic [5:0] obs, exp_v;
        CE = 1'b0;
        CD = 1'b1;
        step();
        obs = {Z0, ZP, CNT};
        checks++;
        if (obs !== 6'b00_0000) begin
            errors++;
            $display("FAIL reset_match: got z0,zp,cnt=%b expected %b", obs, 6'b00_0000);
        end
        CD = 1'b0;
        CE = 1'b1;
        TH = 4'd2;
        set_a(8'hFF);
        for (int i = 0; i < 3; i++) begin
            step();
            obs   = {Z0, ZP, CNT};
            exp_v = {1'(i == 2), 1'(i == 2), 4'(i)};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_requal edge %0d: got z0,zp,cnt=%b expected %b", i + 1, obs, exp_v);
            end
        end
    endtask

    initial begin
        set_a(8'h00);
        @(negedge CK);
        test_reset();
        test_case1();
        test_run_break();
        test_holdoff();
        test_th_edges();
        test_th_lower();
        test_ce_hold();
        test_reset_in_match();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
